// File: rtl/fib_seq_pkg.sv
// Shared types and default configuration for the Fibonacci sequence generator.
package fib_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_e;

  localparam int unsigned DefWidth  = 8;
  localparam int unsigned DefSeedX  = 1;
  localparam int unsigned DefSeedY  = 1;
  localparam int unsigned DefStop   = 100;
  localparam int unsigned DefTarget = 200;
  localparam int unsigned DefCntW   = 8;

endpackage

// File: rtl/fib_flag_cmp.sv
// Zero-latency unsigned compare of the current x/y pair against a fixed target.
module fib_flag_cmp
  import fib_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned TARGET = DefTarget
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_hit,
  output logic             o_above,
  output logic             o_hit_any
);

  localparam logic [WIDTH-1:0] TargetW = WIDTH'(TARGET);

  logic w_x_eq;
  logic w_y_eq;

  assign w_x_eq    = (i_x == TargetW);
  assign w_y_eq    = (i_y == TargetW);
  assign o_hit     = w_x_eq;
  assign o_above   = (i_x > TargetW);
  assign o_hit_any = w_x_eq | w_y_eq;

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci run generator: IDLE -> RUN (x<=x+y, y<=x) until x>=STOP -> DONE.
// Define FIB_SEQ_GEN_OVF_EN to end a run on adder carry-out instead of wrapping.
module fib_seq_gen
  import fib_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned SEED_X = DefSeedX,
  parameter int unsigned SEED_Y = DefSeedY,
  parameter int unsigned STOP   = DefStop,
  parameter int unsigned TARGET = DefTarget,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_cnt,
  output logic             ovf,
  output logic             hit,
  output logic             above,
  output logic             hit_any
);

  localparam logic [WIDTH-1:0] SeedXW = WIDTH'(SEED_X);
  localparam logic [WIDTH-1:0] SeedYW = WIDTH'(SEED_Y);
  localparam logic [WIDTH-1:0] StopW  = WIDTH'(STOP);

  fib_state_e       r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [CNT_W-1:0] w_cnt_inc;

`ifdef FIB_SEQ_GEN_OVF_EN
  logic [WIDTH:0] w_sum_full;
  assign w_sum_full = {1'b0, r_x} + {1'b0, r_y};
  assign w_sum      = w_sum_full[WIDTH-1:0];
  assign w_carry    = w_sum_full[WIDTH];
`else
  assign w_sum   = r_x + r_y;
  assign w_carry = 1'b0;
`endif

  // Counter sticks at all-ones rather than wrapping.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_x     <= SeedXW;
      r_y     <= SeedYW;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= RUN;
            r_x     <= SeedXW;
            r_y     <= SeedYW;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        RUN: begin
          if (!hold) begin
            if (r_x >= StopW) begin
              r_y     <= r_x;
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (w_carry) begin
              // Keep the last valid pair visible; only the count advances.
              r_ovf   <= 1'b1;
              r_cnt   <= w_cnt_inc;
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_x   <= w_sum;
              r_y   <= r_x;
              r_cnt <= w_cnt_inc;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign x_o      = r_x;
  assign y_o      = r_y;
  assign busy     = r_busy;
  assign done     = r_done;
  assign step_cnt = r_cnt;
  assign ovf      = r_ovf;

  fib_flag_cmp #(
    .WIDTH  (WIDTH),
    .TARGET (TARGET)
  ) u_flag_cmp (
    .i_x       (r_x),
    .i_y       (r_y),
    .o_hit     (hit),
    .o_above   (above),
    .o_hit_any (hit_any)
  );

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench: default, TARGET=144 and STOP=255 instances share one stimulus stream.
module tb_fib_seq_gen;

  logic clk = 1'b0;
  logic reset, start, hold;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic [7:0] a_x, a_y, a_cnt, t_x, t_y, t_cnt, w_x, w_y, w_cnt;
  logic a_busy, a_done, a_ovf, a_hit, a_above, a_hany;
  logic t_busy, t_done, t_ovf, t_hit, t_above, t_hany;
  logic w_busy, w_done, w_ovf, w_hit, w_above, w_hany;

  fib_seq_gen u_dut_a (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .x_o(a_x), .y_o(a_y), .busy(a_busy), .done(a_done), .step_cnt(a_cnt),
    .ovf(a_ovf), .hit(a_hit), .above(a_above), .hit_any(a_hany)
  );

  fib_seq_gen #(.TARGET(144)) u_dut_t (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .x_o(t_x), .y_o(t_y), .busy(t_busy), .done(t_done), .step_cnt(t_cnt),
    .ovf(t_ovf), .hit(t_hit), .above(t_above), .hit_any(t_hany)
  );

  fib_seq_gen #(.STOP(255)) u_dut_w (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .x_o(w_x), .y_o(w_y), .busy(w_busy), .done(w_done), .step_cnt(w_cnt),
    .ovf(w_ovf), .hit(w_hit), .above(w_above), .hit_any(w_hany)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; hold = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_busy, a_done, a_x, a_y, a_cnt, a_ovf} !== {1'b0, 1'b0, 8'd1, 8'd1, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", {a_busy, a_done, a_x, a_y, a_cnt, a_ovf},
               {1'b0, 1'b0, 8'd1, 8'd1, 8'd0, 1'b0});
    end
    checks++;
    if ({a_hit, a_above, a_hany, t_hit, t_hany} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {a_hit, a_above, a_hany, t_hit, t_hany});
    end
    hold = 1'b1;
    tick();
    hold = 1'b0;
    checks++;
    if ({a_busy, a_done, a_x} !== {1'b0, 1'b0, 8'd1}) begin
      failures++;
      $display("FAIL idle_stays got=%h exp=%h", {a_busy, a_done, a_x}, {2'b00, 8'd1});
    end
  endtask

  task automatic test_run();
    logic [7:0] exp_x [10];
    logic [7:0] exp_y;
    exp_x = '{8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144};
    exp_y = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({a_busy, a_done, a_x, a_y, a_cnt} !== {1'b1, 1'b0, 8'd1, 8'd1, 8'd0}) begin
      failures++;
      $display("FAIL start_load got=%h exp=%h", {a_busy, a_done, a_x, a_y, a_cnt},
               {2'b10, 8'd1, 8'd1, 8'd0});
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({a_x, a_y, a_cnt} !== {exp_x[i], exp_y, 8'(i + 1)}) begin
        failures++;
        $display("FAIL run_step%0d got=%h exp=%h", i, {a_x, a_y, a_cnt},
                 {exp_x[i], exp_y, 8'(i + 1)});
      end
      checks++;
      if ({t_hit, t_above} !== {(exp_x[i] == 8'd144), 1'b0}) begin
        failures++;
        $display("FAIL target_flags%0d got=%b exp=%b", i, {t_hit, t_above},
                 {(exp_x[i] == 8'd144), 1'b0});
      end
      exp_y = exp_x[i];
    end
    tick();
    checks++;
    if ({a_busy, a_done, a_x, a_y, a_cnt, a_hit, a_above, a_ovf} !==
        {1'b0, 1'b1, 8'd144, 8'd144, 8'd10, 3'b000}) begin
      failures++;
      $display("FAIL done_state got=%h exp=%h",
               {a_busy, a_done, a_x, a_y, a_cnt, a_hit, a_above, a_ovf},
               {2'b01, 8'd144, 8'd144, 8'd10, 3'b000});
    end
    checks++;
    if ({t_done, t_hit, t_above, t_hany} !== 4'b1101) begin
      failures++;
      $display("FAIL target_done got=%b exp=1101", {t_done, t_hit, t_above, t_hany});
    end
    checks++;
    if ({w_busy, w_x, w_y, w_cnt, w_above} !== {1'b1, 8'd233, 8'd144, 8'd11, 1'b1}) begin
      failures++;
      $display("FAIL wide_pre_carry got=%h exp=%h", {w_busy, w_x, w_y, w_cnt, w_above},
               {1'b1, 8'd233, 8'd144, 8'd11, 1'b1});
    end
    tick();
`ifdef FIB_SEQ_GEN_OVF_EN
    checks++;
    if ({w_done, w_ovf, w_x, w_y, w_cnt} !== {1'b1, 1'b1, 8'd233, 8'd144, 8'd12}) begin
      failures++;
      $display("FAIL carry_step got=%h exp=%h", {w_done, w_ovf, w_x, w_y, w_cnt},
               {2'b11, 8'd233, 8'd144, 8'd12});
    end
`else
    checks++;
    if ({w_busy, w_ovf, w_x, w_y, w_cnt} !== {1'b1, 1'b0, 8'd121, 8'd233, 8'd12}) begin
      failures++;
      $display("FAIL carry_step got=%h exp=%h", {w_busy, w_ovf, w_x, w_y, w_cnt},
               {2'b10, 8'd121, 8'd233, 8'd12});
    end
`endif
    checks++;
    if ({a_done, a_x, a_y, a_cnt} !== {1'b1, 8'd144, 8'd144, 8'd10}) begin
      failures++;
      $display("FAIL done_holds got=%h exp=%h", {a_done, a_x, a_y, a_cnt},
               {1'b1, 8'd144, 8'd144, 8'd10});
    end
  endtask

  task automatic test_hold();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++;
    if ({a_x, a_y, a_cnt} !== {8'd13, 8'd8, 8'd5}) begin
      failures++;
      $display("FAIL hold_pre got=%h exp=%h", {a_x, a_y, a_cnt}, {8'd13, 8'd8, 8'd5});
    end
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({a_busy, a_x, a_y, a_cnt} !== {1'b1, 8'd13, 8'd8, 8'd5}) begin
        failures++;
        $display("FAIL hold_cyc%0d got=%h exp=%h", i, {a_busy, a_x, a_y, a_cnt},
                 {1'b1, 8'd13, 8'd8, 8'd5});
      end
    end
    hold = 1'b0;
    tick();
    checks++;
    if ({a_x, a_y, a_cnt} !== {8'd21, 8'd13, 8'd6}) begin
      failures++;
      $display("FAIL hold_resume got=%h exp=%h", {a_x, a_y, a_cnt}, {8'd21, 8'd13, 8'd6});
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    checks++;
    if (a_x !== 8'd34) begin
      failures++;
      $display("FAIL mid_pre got=%0d exp=34", a_x);
    end
    reset = 1'b0; start = 1'b1; hold = 1'b1;
    tick();
    reset = 1'b1; start = 1'b0; hold = 1'b0;
    checks++;
    if ({a_busy, a_done, a_x, a_y, a_cnt} !== {1'b0, 1'b0, 8'd1, 8'd1, 8'd0}) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=%h", {a_busy, a_done, a_x, a_y, a_cnt},
               {2'b00, 8'd1, 8'd1, 8'd0});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = a_done;
    end
    checks++;
    if ({seen, a_x, a_y, a_cnt} !== {1'b1, 8'd144, 8'd144, 8'd10}) begin
      failures++;
      $display("FAIL rerun_done got=%h exp=%h", {seen, a_x, a_y, a_cnt},
               {1'b1, 8'd144, 8'd144, 8'd10});
    end
  endtask

  task automatic test_start();
    bit seen;
    do_reset();
    start = 1'b1; hold = 1'b1;
    tick();
    hold = 1'b0;
    checks++;
    if ({a_busy, a_x, a_cnt} !== {1'b1, 8'd1, 8'd0}) begin
      failures++;
      $display("FAIL start_hold_idle got=%h exp=%h", {a_busy, a_x, a_cnt}, {1'b1, 8'd1, 8'd0});
    end
    tick();
    checks++;
    if ({a_x, a_cnt} !== {8'd2, 8'd1}) begin
      failures++;
      $display("FAIL start_in_run1 got=%h exp=%h", {a_x, a_cnt}, {8'd2, 8'd1});
    end
    tick();
    start = 1'b0;
    checks++;
    if ({a_x, a_y, a_cnt} !== {8'd3, 8'd2, 8'd2}) begin
      failures++;
      $display("FAIL start_in_run2 got=%h exp=%h", {a_x, a_y, a_cnt}, {8'd3, 8'd2, 8'd2});
    end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = a_done;
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL reach_done got=%b exp=1", seen);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({a_busy, a_done, a_x, a_y, a_cnt} !== {1'b1, 1'b0, 8'd1, 8'd1, 8'd0}) begin
      failures++;
      $display("FAIL restart_done got=%h exp=%h", {a_busy, a_done, a_x, a_y, a_cnt},
               {2'b10, 8'd1, 8'd1, 8'd0});
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; hold = 1'b0;
    test_reset();
    test_run();
    test_hold();
    test_reset_mid_run();
    test_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fib_seq_gen.md
FIB_SEQ_GEN -- requirements
Module: fib_seq_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): WIDTH, 8, datapath width of x/y; SEED_X, 1, x load value; SEED_Y, 1, y load value; STOP, 100, x threshold that ends a run; TARGET, 200, flag compare value; CNT_W, 8, step counter width.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1 clock.
- reset in 1 reset, synchronous, active-low.
- start in 1 run request.
- hold in 1 freeze request during run.
- x_o out WIDTH current x.
- y_o out WIDTH current y.
- busy out 1 state==RUN.
- done out 1 state==DONE.
- step_cnt out CNT_W number of x updates in this run.
- ovf out 1 sticky adder carry-out.
- hit out 1 x==TARGET.
- above out 1 x>TARGET (unsigned).
- hit_any out 1 (x==TARGET)||(y==TARGET).

Function
REQ-003 FSM states SHALL be IDLE, RUN and DONE, all registered on posedge clk.
REQ-004 In IDLE or DONE with start=1, the block SHALL load x=SEED_X, y=SEED_Y, step_cnt=0 and ovf=0, and enter RUN on the same edge.
REQ-005 start SHALL be ignored in RUN.
REQ-006 In RUN with hold=0 and x<STOP, each edge SHALL update x<=x+y (WIDTH-bit result), y<=old x, and step_cnt<=step_cnt+1.
REQ-007 step_cnt SHALL saturate at 2^CNT_W-1.
REQ-008 In RUN with hold=0 and x>=STOP, one edge SHALL set y<=x, leave x unchanged, and enter DONE.
REQ-009 In RUN with hold=1, all registers SHALL be unchanged; hold SHALL have no effect outside RUN.
REQ-010 In DONE, x, y, step_cnt and ovf SHALL hold until start or reset.
REQ-011 hit, above and hit_any SHALL be combinational from the registered x and y, with zero latency.
REQ-012 All comparisons SHALL be unsigned at WIDTH bits; STOP and TARGET SHALL be truncated to WIDTH bits.
REQ-013 If reset and start are both active on an edge, reset SHALL win.

Reset
REQ-014 With reset=0 at a posedge, the block SHALL set state=IDLE, x=SEED_X, y=SEED_Y, step_cnt=0 and ovf=0, giving busy=0 and done=0.
REQ-015 Reset SHALL take effect from any state, including RUN under hold, with no partial update.

Configuration
REQ-016 With macro FIB_SEQ_GEN_OVF_EN defined, on a RUN step whose x+y carries out of WIDTH bits the block SHALL:
- leave x and y unchanged;
- set ovf=1;
- increment step_cnt;
- enter DONE.
REQ-017 With FIB_SEQ_GEN_OVF_EN undefined, the sum SHALL wrap modulo 2^WIDTH, the run SHALL continue per REQ-006/008, and ovf SHALL be constant 0.

Structure
REQ-018 Package fib_seq_pkg SHALL hold:
- the state enum (IDLE/RUN/DONE);
- the default parameter constants.
REQ-019 Sub-module fib_flag_cmp (inputs x, y, TARGET; outputs hit, above, hit_any) SHALL implement REQ-011 and be instantiated once.

Verification
REQ-020 Defaults, start pulse for 1 cycle:
- x SHALL step 1,2,3,5,8,13,21,34,55,89,144;
- then DONE with x=144, y=144, step_cnt=10, hit=0, above=0, ovf=0.
REQ-021 TARGET=144, run as REQ-020: hit=1 and above=0 from the edge where x becomes 144; hit_any=1 in DONE.
REQ-022 hold=1 for 3 cycles when x=13, y=8: x and y SHALL stay 13/8 and step_cnt SHALL stay 5, then resume with x=21.
REQ-023 WIDTH=8, STOP=255, macro defined: after x=233, y=144 the next step SHALL give ovf=1, DONE, x=233, step_cnt=12. Macro undefined: that step SHALL give x=121, y=233, ovf=0, and the run continues.
REQ-024 reset=0 for one edge while x=34 in RUN: next cycle state=IDLE, x=1, y=1, step_cnt=0, busy=0; a later start reproduces REQ-020.
REQ-025 start asserted during RUN and start asserted in DONE:
- during RUN, no effect;
- in DONE, reloads seeds, step_cnt=0, busy=1 next cycle.
